// File: rtl/sdio_seq_pkg.sv
// Shared types and constants for the SDIO data-transfer sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: sequencer state encoding, SDIO transfer limits and the helper
// that turns a latched request into a total byte count.
package sdio_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_WAIT_FIN = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } seq_state_e;

  localparam int SDIO_MAX_COUNT = 512;
  localparam int SDIO_MAX_BLOCK = 2048;
  localparam int TOTAL_W        = 21;  // 512 blocks * 2048 bytes = 2^20
  localparam int COUNT_W        = 9;
  localparam int BLKSZ_W        = 12;
  localparam int FUNC_SEL_W     = 4;

  // Memory target sits above the eight I/O functions on the mux select.
  localparam logic [FUNC_SEL_W-1:0] FUNC_SEL_MEM = 4'd8;

  // Bytes moved by one transfer. A CMD53 count of zero encodes the maximum.
  function automatic logic [TOTAL_W-1:0] total_bytes(
    input logic               cmd52,
    input logic               block,
    input logic [COUNT_W-1:0] count,
    input logic [BLKSZ_W-1:0] block_size
  );
    logic [TOTAL_W-1:0] n;
    n = (count == '0) ? TOTAL_W'(SDIO_MAX_COUNT) : TOTAL_W'(count);
    if (cmd52) begin
      return TOTAL_W'(1);
    end else if (block) begin
      return n * TOTAL_W'(block_size);
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/sdio_xfer_timeout.sv
// Idle-cycle watchdog for the sequencer: counts enabled cycles since the last clear.
// Latency: o_expired pulses the cycle after the count sits at TIMEOUT_CYCLES-1 while enabled.
// Backpressure: none; free-running while i_en, i_clr reloads the count to zero.
//
// Ports: clk/rst (sync, active-high), i_en (count this cycle), i_clr (reload
// zero, wins over i_en), o_expired (registered 1-cycle expiry pulse).
module sdio_xfer_timeout #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] ONE   = TIMEOUT_WIDTH'(1);

  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
  logic                     expired_q, expired_d;

  always_comb begin
    count_d   = count_q;
    expired_d = 1'b0;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en) begin
      // Saturate at the limit; the owner leaves the enabled state on expiry.
      if (count_q == LIMIT) begin
        expired_d = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign o_expired = expired_q;

endmodule

// File: rtl/sdio_xfer_sequencer.sv
// Sequences one SDIO CMD52/CMD53 data transfer through the function/memory data mux.
// Latency: accept -> o_activate 2 cycles; finished/abort -> o_done 1 cycle.
// Backpressure: none; requests outside IDLE are dropped, byte strobes are counted as presented.
//
// Ports: request (i_xfer_*, i_block_size) sampled on i_xfer_stb in IDLE;
// i_byte_stb/i_finished/i_abort from PHY, mux and CCCR; mux controls
// (o_func_sel, o_mem_sel, o_cmd_bus_sel, o_activate); status pulses
// (o_block_stb, o_done, o_aborted, o_timeout), sticky o_overrun, o_bytes_left.
module sdio_xfer_sequencer
  import sdio_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_xfer_stb,
  input  logic                  i_xfer_cmd52,
  input  logic                  i_xfer_wr,
  input  logic [2:0]            i_xfer_func,
  input  logic                  i_xfer_mem,
  input  logic                  i_xfer_block,
  input  logic [COUNT_W-1:0]    i_xfer_count,
  input  logic [BLKSZ_W-1:0]    i_block_size,
  input  logic                  i_byte_stb,
  input  logic                  i_finished,
  input  logic                  i_abort,
  output logic [FUNC_SEL_W-1:0] o_func_sel,
  output logic                  o_mem_sel,
  output logic                  o_cmd_bus_sel,
  output logic                  o_activate,
  output logic                  o_busy,
  output logic                  o_block_stb,
  output logic                  o_done,
  output logic                  o_aborted,
  output logic                  o_timeout,
  output logic                  o_overrun,
  output logic [TOTAL_W-1:0]    o_bytes_left
);

  seq_state_e state_q, state_d;

  logic [FUNC_SEL_W-1:0] func_sel_q, func_sel_d;
  logic                  mem_sel_q, mem_sel_d;
  logic                  cmd_bus_q, cmd_bus_d;
  logic                  xfer_wr_q, xfer_wr_d;
  logic                  block_mode_q, block_mode_d;
  logic [BLKSZ_W-1:0]    blk_size_q, blk_size_d;
  logic [BLKSZ_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic [TOTAL_W-1:0]    bytes_left_q, bytes_left_d;
  logic                  aborted_q, aborted_d;
  logic                  overrun_q, overrun_d;
  logic                  block_stb_q, block_stb_d;

  logic accept;
  logic in_xfer;
  logic abort_hit;
  logic count_stb;
  logic last_byte;
  logic blk_last;
  logic tmo_en;
  logic tmo_clr;
  logic tmo_expired;

  // Direction does not alter sequencing: the PHY already routes wr_stb or
  // rd_stb onto i_byte_stb. The latched copy is kept for debug visibility.
  logic unused_xfer_wr;
  assign unused_xfer_wr = xfer_wr_q;

  assign accept    = (state_q == ST_IDLE) && i_xfer_stb;
  assign in_xfer   = (state_q == ST_SETUP) || (state_q == ST_ACTIVE) ||
                     (state_q == ST_WAIT_FIN);
  assign abort_hit = in_xfer && i_abort;
  // Abort outranks a same-cycle byte strobe, so that byte is not counted.
  assign count_stb = (state_q == ST_ACTIVE) && i_byte_stb && !i_abort;
  assign last_byte = (bytes_left_q == TOTAL_W'(1));
  assign blk_last  = (blk_cnt_q == (blk_size_q - 12'd1));

  // Watchdog runs while the mux is active. Only counted strobes re-arm it:
  // stray strobes in WAIT_FIN must not hide a function that never finishes.
  assign tmo_en  = (state_q == ST_ACTIVE) || (state_q == ST_WAIT_FIN);
  assign tmo_clr = !tmo_en || ((state_q == ST_ACTIVE) && i_byte_stb);

  sdio_xfer_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_en      (tmo_en),
    .i_clr     (tmo_clr),
    .o_expired (tmo_expired)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state. Priority inside a transfer: abort, timeout, finished,
  // then the last byte. Finished with bytes still left is an early
  // completion and leaves the residual in o_bytes_left.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_xfer_stb) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = abort_hit ? ST_DONE : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (i_abort) begin
          state_d = ST_DONE;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end else if (i_finished) begin
          state_d = ST_DONE;
        end else if (i_byte_stb && last_byte) begin
          state_d = ST_WAIT_FIN;
        end
      end
      ST_WAIT_FIN: begin
        if (i_abort) begin
          state_d = ST_DONE;
        end else if (tmo_expired) begin
          state_d = ST_ERR;
        end else if (i_finished) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Selects are live from SETUP through DONE/ERR so they
  // settle a cycle ahead of activate and stay put until the mux is idle.
  // ---------------------------------------------------------------------
  always_comb begin
    o_func_sel    = '0;
    o_mem_sel     = 1'b0;
    o_cmd_bus_sel = 1'b0;
    o_activate    = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_aborted     = 1'b0;
    o_timeout     = 1'b0;
    if (state_q != ST_IDLE) begin
      o_func_sel    = func_sel_q;
      o_mem_sel     = mem_sel_q;
      o_cmd_bus_sel = cmd_bus_q;
      o_busy        = 1'b1;
    end
    o_activate = (state_q == ST_ACTIVE) || (state_q == ST_WAIT_FIN);
    o_done     = (state_q == ST_DONE);
    o_aborted  = (state_q == ST_DONE) && aborted_q;
    o_timeout  = (state_q == ST_ERR);
  end

  assign o_block_stb  = block_stb_q;
  assign o_overrun    = overrun_q;
  assign o_bytes_left = bytes_left_q;

  // ---------------------------------------------------------------------
  // Transfer context and byte/block accounting
  // ---------------------------------------------------------------------
  always_comb begin
    func_sel_d   = func_sel_q;
    mem_sel_d    = mem_sel_q;
    cmd_bus_d    = cmd_bus_q;
    xfer_wr_d    = xfer_wr_q;
    block_mode_d = block_mode_q;
    blk_size_d   = blk_size_q;
    blk_cnt_d    = blk_cnt_q;
    bytes_left_d = bytes_left_q;
    aborted_d    = aborted_q;
    overrun_d    = overrun_q;
    block_stb_d  = 1'b0;

    if (accept) begin
      func_sel_d   = i_xfer_mem ? FUNC_SEL_MEM : {1'b0, i_xfer_func};
      mem_sel_d    = i_xfer_mem;
      cmd_bus_d    = i_xfer_cmd52;
      xfer_wr_d    = i_xfer_wr;
      // Block mode only exists for CMD53; CMD52 is always a single byte.
      block_mode_d = i_xfer_block && !i_xfer_cmd52;
      blk_size_d   = i_block_size;
      blk_cnt_d    = '0;
      bytes_left_d = total_bytes(i_xfer_cmd52, i_xfer_block && !i_xfer_cmd52,
                                 i_xfer_count, i_block_size);
      aborted_d    = 1'b0;
      overrun_d    = 1'b0;
    end

    if (count_stb) begin
      bytes_left_d = bytes_left_q - TOTAL_W'(1);
      if (block_mode_q) begin
        if (blk_last) begin
          blk_cnt_d   = '0;
          block_stb_d = 1'b1;
        end else begin
          blk_cnt_d = blk_cnt_q + 12'd1;
        end
      end
    end

    if ((state_q == ST_WAIT_FIN) && i_byte_stb) begin
      overrun_d = 1'b1;
    end

    if (abort_hit) begin
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      func_sel_q   <= '0;
      mem_sel_q    <= 1'b0;
      cmd_bus_q    <= 1'b0;
      xfer_wr_q    <= 1'b0;
      block_mode_q <= 1'b0;
      blk_size_q   <= '0;
      blk_cnt_q    <= '0;
      bytes_left_q <= '0;
      aborted_q    <= 1'b0;
      overrun_q    <= 1'b0;
      block_stb_q  <= 1'b0;
    end else begin
      func_sel_q   <= func_sel_d;
      mem_sel_q    <= mem_sel_d;
      cmd_bus_q    <= cmd_bus_d;
      xfer_wr_q    <= xfer_wr_d;
      block_mode_q <= block_mode_d;
      blk_size_q   <= blk_size_d;
      blk_cnt_q    <= blk_cnt_d;
      bytes_left_q <= bytes_left_d;
      aborted_q    <= aborted_d;
      overrun_q    <= overrun_d;
      block_stb_q  <= block_stb_d;
    end
  end

endmodule

// File: tb/tb_sdio_xfer_sequencer.sv
// Scoreboard bench for sdio_xfer_sequencer: the driver pushes the expected
// completion of every transfer it issues; a monitor pops and compares on
// each o_done / o_timeout. Inputs change and outputs are sampled on negedge.
module tb_sdio_xfer_sequencer;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_xfer_stb, i_xfer_cmd52, i_xfer_wr, i_xfer_mem, i_xfer_block;
  logic [2:0]  i_xfer_func;
  logic [8:0]  i_xfer_count;
  logic [11:0] i_block_size;
  logic        i_byte_stb, i_finished, i_abort;
  logic [3:0]  o_func_sel;
  logic        o_mem_sel, o_cmd_bus_sel, o_activate, o_busy, o_block_stb;
  logic        o_done, o_aborted, o_timeout, o_overrun;
  logic [20:0] o_bytes_left;

  sdio_xfer_sequencer #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .i_xfer_stb(i_xfer_stb), .i_xfer_cmd52(i_xfer_cmd52), .i_xfer_wr(i_xfer_wr),
    .i_xfer_func(i_xfer_func), .i_xfer_mem(i_xfer_mem), .i_xfer_block(i_xfer_block),
    .i_xfer_count(i_xfer_count), .i_block_size(i_block_size),
    .i_byte_stb(i_byte_stb), .i_finished(i_finished), .i_abort(i_abort),
    .o_func_sel(o_func_sel), .o_mem_sel(o_mem_sel), .o_cmd_bus_sel(o_cmd_bus_sel),
    .o_activate(o_activate), .o_busy(o_busy), .o_block_stb(o_block_stb),
    .o_done(o_done), .o_aborted(o_aborted), .o_timeout(o_timeout),
    .o_overrun(o_overrun), .o_bytes_left(o_bytes_left)
  );

  always #5 clk = ~clk;

  // kind: 0 = normal done, 1 = aborted done, 2 = timeout
  typedef struct {
    int kind;
    int func_sel;
    int mem_sel;
    int cmd_sel;
    int left;
    int blocks;
    int overrun;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int   blk;
    exp_t e;
    blk = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        blk = 0;
      end else begin
        if (o_block_stb) blk++;
        if (o_done || o_timeout) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("completion_kind", o_timeout ? 2 : (o_aborted ? 1 : 0), e.kind);
            chk("bytes_left", 32'(o_bytes_left), e.left);
            chk("block_pulses", blk, e.blocks);
            chk("activate_low_at_end", 32'(o_activate), 0);
            if (o_timeout) begin
              chk("no_done_on_timeout", 32'(o_done), 0);
            end else begin
              chk("func_sel_at_done", 32'(o_func_sel), e.func_sel);
              chk("mem_sel_at_done", 32'(o_mem_sel), e.mem_sel);
              chk("cmd_bus_sel_at_done", 32'(o_cmd_bus_sel), e.cmd_sel);
              chk("overrun_at_done", 32'(o_overrun), e.overrun);
            end
          end
          blk = 0;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic pulse(input int which);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    case (which)
      0: i_byte_stb = 1'b1;
      1: i_finished = 1'b1;
      default: i_abort = 1'b1;
    endcase
    @(negedge clk);
    i_byte_stb = 1'b0;
    i_finished = 1'b0;
    i_abort    = 1'b0;
  endtask

  task automatic drive_req(input bit cmd52, input bit wr, input int func, input bit mem,
                           input bit block, input int count, input int bsize);
    i_xfer_stb   = 1'b1;
    i_xfer_cmd52 = cmd52;
    i_xfer_wr    = wr;
    i_xfer_func  = 3'(func);
    i_xfer_mem   = mem;
    i_xfer_block = block;
    i_xfer_count = 9'(count);
    i_block_size = 12'(bsize);
  endtask

  // A request while the sequencer is busy, with scrambled fields: must be ignored.
  task automatic junk_req();
    drive_req($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 511),
              $urandom_range(1, 2048));
  endtask

  // mode: 0 normal, 1 abort after k bytes, 2 early finished after k bytes,
  //       3 stray strobe in WAIT_FIN, 4 last byte coincident with finished
  task automatic run_xfer(input bit cmd52, input bit wr, input int func, input bit mem,
                          input bit block, input int count, input int bsize,
                          input int mode, input int k);
    int   n, total, sent;
    bit   bm;
    exp_t e;
    n     = (count == 0) ? 512 : count;
    bm    = block && !cmd52;
    total = cmd52 ? 1 : (bm ? n * bsize : n);
    sent  = (mode == 1 || mode == 2) ? k : total;
    e.kind     = (mode == 1) ? 1 : 0;
    e.func_sel = mem ? 8 : func;
    e.mem_sel  = mem;
    e.cmd_sel  = cmd52;
    e.left     = total - sent;
    e.blocks   = bm ? sent / bsize : 0;
    e.overrun  = (mode == 3) ? 1 : 0;
    exp_q.push_back(e);

    drive_req(cmd52, wr, func, mem, block, count, bsize);
    @(negedge clk);                       // SETUP
    i_xfer_stb = 1'b0;
    if ($urandom_range(0, 1) == 1) junk_req();
    chk("busy_in_setup", 32'(o_busy), 1);
    chk("activate_low_in_setup", 32'(o_activate), 0);
    chk("func_sel_in_setup", 32'(o_func_sel), e.func_sel);
    @(negedge clk);                       // first ACTIVE cycle
    i_xfer_stb = 1'b0;
    chk("activate_after_2", 32'(o_activate), 1);

    for (int i = 0; i < sent; i++) begin
      if (mode == 4 && i == sent - 1) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        i_byte_stb = 1'b1;
        i_finished = 1'b1;
        @(negedge clk);
        i_byte_stb = 1'b0;
        i_finished = 1'b0;
      end else begin
        pulse(0);
      end
    end
    case (mode)
      1: pulse(2);
      2: pulse(1);
      3: begin
        i_byte_stb = 1'b1;
        @(negedge clk);
        i_byte_stb = 1'b0;
        pulse(1);
      end
      4: ;
      default: pulse(1);
    endcase
    // Now in DONE: a request here must be ignored.
    junk_req();
    @(negedge clk);
    i_xfer_stb = 1'b0;
    chk("idle_after_done", 32'(o_busy), 0);
    chk("selects_clear_in_idle", 32'({o_func_sel, o_mem_sel, o_cmd_bus_sel, o_activate}), 0);
    chk("overrun_held_in_idle", 32'(o_overrun), e.overrun);
  endtask

  task automatic run_timeout();
    exp_t e;
    int   cyc;
    e.kind = 2; e.func_sel = 3; e.mem_sel = 0; e.cmd_sel = 0;
    e.left = 5; e.blocks = 0; e.overrun = 0;
    exp_q.push_back(e);
    drive_req(0, 0, 3, 0, 0, 5, 1);
    @(negedge clk);
    i_xfer_stb = 1'b0;
    @(negedge clk);
    chk("tmo_activate_after_2", 32'(o_activate), 1);
    cyc = 0;
    while (!o_timeout && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_cycles_after_active", cyc, 17);
    junk_req();                           // request during ERR is ignored
    @(negedge clk);
    i_xfer_stb = 1'b0;
    chk("idle_after_timeout", 32'(o_busy), 0);
    chk("timeout_is_pulse", 32'(o_timeout), 0);
  endtask

  task automatic run_reset_mid_active();
    drive_req(0, 1, 6, 0, 0, 20, 1);
    @(negedge clk);
    i_xfer_stb = 1'b0;
    @(negedge clk);
    repeat (5) pulse(0);
    chk("left_before_reset", 32'(o_bytes_left), 15);
    rst = 1'b1;
    @(negedge clk);
    chk("flags_zero_after_reset",
        32'({o_func_sel, o_mem_sel, o_cmd_bus_sel, o_activate, o_busy, o_block_stb,
             o_done, o_aborted, o_timeout, o_overrun}), 0);
    chk("bytes_left_zero_after_reset", 32'(o_bytes_left), 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    bit c52, blk, mem;
    int cnt, bs, tot, md, k;
    rst = 1'b1;
    i_xfer_stb = 0; i_xfer_cmd52 = 0; i_xfer_wr = 0; i_xfer_func = 0;
    i_xfer_mem = 0; i_xfer_block = 0; i_xfer_count = 0; i_block_size = 0;
    i_byte_stb = 0; i_finished = 0; i_abort = 0;
    repeat (3) @(negedge clk);
    chk("reset_flags",
        32'({o_func_sel, o_mem_sel, o_cmd_bus_sel, o_activate, o_busy, o_block_stb,
             o_done, o_aborted, o_timeout, o_overrun}), 0);
    chk("reset_bytes_left", 32'(o_bytes_left), 0);
    rst = 1'b0;
    @(negedge clk);

    run_xfer(1, 1, 1, 0, 0, 5, 4, 0, 0);      // CMD52 write, func 1
    run_xfer(0, 0, 2, 0, 1, 3, 64, 0, 0);     // 3 blocks of 64
    run_xfer(0, 0, 5, 1, 0, 0, 16, 0, 0);     // mem, count 0 -> 512 bytes
    run_xfer(0, 1, 3, 0, 0, 100, 1, 1, 10);   // abort after 10 of 100
    run_xfer(0, 1, 4, 0, 0, 7, 1, 3, 0);      // stray strobe -> overrun
    run_xfer(0, 0, 7, 0, 1, 2, 5, 0, 0);      // overrun cleared on accept
    run_timeout();
    run_reset_mid_active();
    run_xfer(0, 0, 1, 0, 1, 2, 3, 4, 0);      // last byte with finished

    for (int t = 0; t < 30; t++) begin
      c52 = ($urandom_range(0, 3) == 0);
      blk = $urandom_range(0, 1);
      mem = ($urandom_range(0, 4) == 0);
      if (blk) begin
        cnt = $urandom_range(1, 6);
        bs  = $urandom_range(1, 24);
      end else begin
        cnt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
        bs  = $urandom_range(1, 2048);
      end
      tot = c52 ? 1 : (blk ? cnt * bs : ((cnt == 0) ? 512 : cnt));
      md  = $urandom_range(0, 4);
      k   = $urandom_range(0, tot - 1);
      run_xfer(c52, $urandom_range(0, 1), $urandom_range(0, 7), mem, blk, cnt, bs, md, k);
    end

    repeat (4) @(negedge clk);
    chk("pending_completions", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
